// File: rtl/rainbow_sequencer.sv
// rainbow_sequencer: button-cycled display mode driving a PWM hue wheel onto the RGB LED and a PWM bar graph onto the LED bar
// CLK clock, RST sync active-high reset, BP debounced button level (high = pressed)
// LED[7:0] bar graph active-low, RGB[2:0] {B,G,R} active-low, MODE[1:0] 0 OFF / 1 BAR / 2 HUE / 3 BOTH
module rainbow_sequencer #(
  parameter int STEP_DIV = 195312,
  parameter int PWM_W = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BP,
  output logic [7:0] LED,
  output logic [2:0] RGB,
  output logic [1:0] MODE
);
  localparam logic [1:0] S_OFF = 2'd0;
  localparam int PW = $clog2(STEP_DIV);
  localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);
  logic             bp_q, press, run, tick;
  logic [1:0]       mode_q, mode_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [7:0]       lvl_q, lvl_d;
  logic [2:0]       ph_q, ph_d;
  logic [PWM_W-1:0] pwm_q;
  logic [7:0]       duty_r, duty_g, duty_b, bar, bar_on, led_q;
  logic [2:0]       rgb_on, rgb_q;
  always_comb begin
    run    = mode_q != S_OFF;
    tick   = run && pre_q == LAST;
    press  = BP & ~bp_q;
    mode_d = press ? mode_q + 2'd1 : mode_q;
    pre_d  = !run ? pre_q : tick ? '0 : pre_q + 1'b1;
    lvl_d  = tick ? lvl_q + 8'd1 : lvl_q;
    ph_d   = (tick && lvl_q == 8'hFF) ? (ph_q == 3'd5 ? 3'd0 : ph_q + 3'd1) : ph_q;
    // ~lvl is 255-lvl: the falling ramp of each phase
    duty_r = (ph_q == 3'd0 || ph_q == 3'd5) ? 8'hFF : ph_q == 3'd1 ? ~lvl_q : ph_q == 3'd4 ? lvl_q : 8'h00;
    duty_g = (ph_q == 3'd1 || ph_q == 3'd2) ? 8'hFF : ph_q == 3'd0 ? lvl_q : ph_q == 3'd3 ? ~lvl_q : 8'h00;
    duty_b = (ph_q == 3'd3 || ph_q == 3'd4) ? 8'hFF : ph_q == 3'd2 ? lvl_q : ph_q == 3'd5 ? ~lvl_q : 8'h00;
    rgb_on = {pwm_q < duty_b, pwm_q < duty_g, pwm_q < duty_r};
    // thermometer of level[7:5]+1 lit LEDs, all sharing one duty-255 gate
    bar    = 8'hFF >> (3'd7 - lvl_q[7:5]);
    bar_on = (pwm_q != '1) ? bar : 8'h00;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      bp_q   <= 1'b1;
      mode_q <= S_OFF;
      pre_q  <= '0;
      lvl_q  <= '0;
      ph_q   <= '0;
      pwm_q  <= '0;
      led_q  <= 8'hFF;
      rgb_q  <= 3'b111;
    end else begin
      bp_q   <= BP;
      mode_q <= mode_d;
      pre_q  <= pre_d;
      lvl_q  <= lvl_d;
      ph_q   <= ph_d;
      pwm_q  <= pwm_q + 1'b1;
      led_q  <= mode_q[0] ? ~bar_on : 8'hFF;
      rgb_q  <= mode_q[1] ? ~rgb_on : 3'b111;
    end
  end
  assign LED  = led_q;
  assign RGB  = rgb_q;
  assign MODE = mode_q;
endmodule

// File: tb/tb_rainbow_sequencer.sv
// tb_rainbow_sequencer: randomized scoreboard bench against a wheel-position reference model
module tb_rainbow_sequencer;
  localparam int SD = 4;
  localparam int KIND [18] = '{1,2,0, 3,1,0, 0,1,2, 0,3,1, 2,0,1, 1,0,3};
  logic CLK = 1'b0, RST = 1'b1, BP = 1'b1;
  logic [7:0] LED;
  logic [2:0] RGB;
  logic [1:0] MODE;
  typedef struct packed {logic [7:0] led; logic [2:0] rgb; logic [1:0] mode;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m_mode, m_h, m_act, m_pwm;
  bit m_bp;
  rainbow_sequencer #(.STEP_DIV(SD), .PWM_W(8)) dut (.CLK(CLK), .RST(RST), .BP(BP), .LED(LED), .RGB(RGB), .MODE(MODE));
  always #5 CLK = ~CLK;
  // 0 off, 1 full, 2 rising ramp, 3 falling ramp
  function automatic int duty(int h, int c);
    int k = KIND[(h / 256) * 3 + c];
    int l = h % 256;
    return k == 0 ? 0 : k == 1 ? 255 : k == 2 ? l : 255 - l;
  endfunction
  initial forever begin
    exp_t e;
    int n;
    bit press;
    @(posedge CLK);
    if (RST) begin
      e = '{8'hFF, 3'b111, 2'd0};
      m_mode = 0; m_h = 0; m_act = 0; m_pwm = 0; m_bp = 1;
    end else begin
      for (int c = 0; c < 3; c++) e.rgb[c] = (m_mode >= 2) ? !(m_pwm < duty(m_h, c)) : 1'b1;
      n = (m_h % 256) / 32 + 1;
      e.led = (m_mode % 2 == 1 && m_pwm < 255) ? ~8'((1 << n) - 1) : 8'hFF;
      press = BP && !m_bp;
      m_bp = BP;
      if (m_mode != 0) begin
        m_act++;
        if (m_act % SD == 0) m_h = (m_h + 1) % 1536;
      end
      if (press) m_mode = (m_mode + 1) % 4;
      m_pwm = (m_pwm + 1) % 256;
      e.mode = 2'(m_mode);
    end
    q.push_back(e);
  end
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({LED, RGB, MODE} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: LED=%h RGB=%b MODE=%0d, expected LED=%h RGB=%b MODE=%0d",
                 $time, LED, RGB, MODE, e.led, e.rgb, e.mode);
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic push(int k);
    BP = 1'b1; cyc(k);
    BP = 1'b0; cyc(k);
  endtask
  initial begin
    cyc(3);
    RST = 1'b0; cyc(6);
    BP = 1'b0; cyc(3);
    push(3);
    repeat (3) push(2);
    cyc(1000);
    repeat (2) push(2);
    cyc(6 * 256 * SD + 300);
    push(2);
    cyc(3000);
    push(2); push(2);
    cyc(2000);
    repeat (400) begin
      BP = 1'($urandom_range(0, 1));
      RST = ($urandom_range(0, 59) == 0);
      cyc($urandom_range(1, 40));
    end
    RST = 1'b0;
    cyc(20);
    @(negedge CLK); #1;
    checks++;
    if (checks < 10000) begin
      errors++;
      $display("FAIL coverage: %0d checks, required at least 10000", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
